// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle of the decode/execute status signals that the hazard controller
// watches, and the stall/bubble/UART-request controls that it drives back.
//
// The master modport is the pipeline side. The slave modport is the
// controller.
//   decode  : id_read_reg1/2, id_readf1/2, id_reg1_addr/id_reg2_addr
//   execute : ex_mem_read, ex_reg_write, ex_writef, ex_write_reg,
//             ex_data_in, ex_data_out, branch_wrong
//   memory  : mem_busy
//   uart    : io_ack (in), io_req (out)
//   control : stall, bubble_ex (out)
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;

   localparam int unsigned REG_AW = 5;

   logic              id_read_reg1;
   logic              id_read_reg2;
   logic              id_readf1;
   logic              id_readf2;
   logic [REG_AW-1:0] id_reg1_addr;
   logic [REG_AW-1:0] id_reg2_addr;

   logic              ex_mem_read;
   logic              ex_reg_write;
   logic              ex_writef;
   logic [REG_AW-1:0] ex_write_reg;
   logic              ex_data_in;
   logic              ex_data_out;
   logic              branch_wrong;

   logic              mem_busy;
   logic              io_ack;

   logic              stall;
   logic              bubble_ex;
   logic              io_req;

   modport master (
      output id_read_reg1, id_read_reg2, id_readf1, id_readf2,
             id_reg1_addr, id_reg2_addr,
             ex_mem_read, ex_reg_write, ex_writef, ex_write_reg,
             ex_data_in, ex_data_out, branch_wrong,
             mem_busy, io_ack,
      input  stall, bubble_ex, io_req
   );

   modport slave (
      input  id_read_reg1, id_read_reg2, id_readf1, id_readf2,
             id_reg1_addr, id_reg2_addr,
             ex_mem_read, ex_reg_write, ex_writef, ex_write_reg,
             ex_data_in, ex_data_out, branch_wrong,
             mem_busy, io_ack,
      output stall, bubble_ex, io_req
   );

endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// This block controls pipeline hazards and stalls for the RV32 integer/float
// core. It handles four cases:
//   - load-use hazards
//   - data-memory wait states
//   - UART in/out handshakes
//   - branch-mispredict abort
// It also keeps saturating performance counters.
//
// The controls are combinational from the state and the current inputs, so a
// hazard stalls the pipe in the same cycle in which it appears. The state and
// the counters are registered.
//
// Build option:
//   PIPE_IO_HANDSHAKE_EN  when defined, in/out instructions wait in IOW for
//                         io_ack. When undefined, they complete in one cycle,
//                         io_req is held at 0, io_ack is ignored and IOW is
//                         never entered.
//
// Ports:
//   clk           core clock
//   rst           synchronous active-low reset
//   bus           pipe_hazard_ctrl_if.slave (decode/execute status, stall,
//                 bubble_ex, io_req/io_ack)
//   state         current state: RUN=0, LDUSE=1, MEMW=2, IOW=3
//   stall_cycles  saturating count of cycles with stall=1
//   bubbles       saturating count of cycles with bubble_ex=1
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   pipe_hazard_ctrl_if.slave    bus,
   output logic [1:0]           state,
   output logic [CNT_W-1:0]     stall_cycles,
   output logic [CNT_W-1:0]     bubbles
);

   localparam int unsigned REG_AW = 5;
   localparam int unsigned ST_W   = 2;

`ifdef PIPE_IO_HANDSHAKE_EN
   localparam bit IO_EN = 1'b1;
`else
   localparam bit IO_EN = 1'b0;
`endif

   typedef enum logic [ST_W-1:0] {
      ST_RUN   = 2'd0,
      ST_LDUSE = 2'd1,
      ST_MEMW  = 2'd2,
      ST_IOW   = 2'd3
   } state_e;

   state_e             state_q;
   state_e             state_d;

   logic [CNT_W-1:0]   stall_cycles_q;
   logic [CNT_W-1:0]   stall_cycles_d;
   logic [CNT_W-1:0]   bubbles_q;
   logic [CNT_W-1:0]   bubbles_d;

   logic               src1_en_c;
   logic               src2_en_c;
   logic               src1_hit_c;
   logic               src2_hit_c;
   logic               ldhit_c;
   logic               io_start_c;
   logic               io_done_c;
   logic               stall_c;
   logic               bubble_c;
   logic               io_req_c;

   // Load-use match. A source is enabled when it reads either register file.
   // The register-file type must agree with the load destination, and
   // integer x0 never matches.
   always_comb begin
      src1_en_c  = bus.id_read_reg1 | bus.id_readf1;
      src2_en_c  = bus.id_read_reg2 | bus.id_readf2;

      src1_hit_c = src1_en_c
                 & (bus.ex_writef == bus.id_readf1)
                 & (bus.ex_write_reg == bus.id_reg1_addr)
                 & (bus.ex_writef | (bus.ex_write_reg != REG_AW'(0)));

      src2_hit_c = src2_en_c
                 & (bus.ex_writef == bus.id_readf2)
                 & (bus.ex_write_reg == bus.id_reg2_addr)
                 & (bus.ex_writef | (bus.ex_write_reg != REG_AW'(0)));

      ldhit_c    = bus.ex_mem_read & bus.ex_reg_write & (src1_hit_c | src2_hit_c);
   end

   // UART handshake qualifiers. Both are held low when the handshake is
   // compiled out.
   always_comb begin
      io_start_c = IO_EN & (bus.ex_data_in | bus.ex_data_out);
      io_done_c  = IO_EN & bus.io_ack;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state. A mispredict in RUN wins over everything else. A mem_busy
   // that arrives during LDUSE or IOW waits until the return to RUN.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN: begin
            if (bus.branch_wrong) begin
               state_d = ST_RUN;
            end else if (bus.mem_busy) begin
               state_d = ST_MEMW;
            end else if (io_start_c) begin
               state_d = ST_IOW;
            end else if (ldhit_c) begin
               state_d = ST_LDUSE;
            end
         end
         ST_LDUSE: begin
            state_d = ST_RUN;
         end
         ST_MEMW: begin
            if (!bus.mem_busy) begin
               state_d = ST_RUN;
            end
         end
         ST_IOW: begin
            if (io_done_c || !IO_EN) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Output decode from the state being entered. The bubble is issued in the
   // hazard cycle itself; the LDUSE cycle that follows is clean. The cycle
   // that releases a wait (mem_busy low, or io_ack) already drops stall.
   always_comb begin
      stall_c  = 1'b0;
      bubble_c = 1'b0;
      io_req_c = 1'b0;
      if (rst) begin
         unique case (state_d)
            ST_LDUSE: begin
               stall_c  = 1'b1;
               bubble_c = 1'b1;
            end
            ST_MEMW: begin
               stall_c  = 1'b1;
            end
            ST_IOW: begin
               stall_c  = 1'b1;
               io_req_c = IO_EN;
            end
            default: begin
               stall_c  = 1'b0;
            end
         endcase
      end
   end

   // Saturating performance counters.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      bubbles_d      = bubbles_q;
      if (stall_c && (stall_cycles_q != {CNT_W{1'b1}})) begin
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
      if (bubble_c && (bubbles_q != {CNT_W{1'b1}})) begin
         bubbles_d = bubbles_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cycles_q <= '0;
         bubbles_q      <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         bubbles_q      <= bubbles_d;
      end
   end

   assign bus.stall     = stall_c;
   assign bus.bubble_ex = bubble_c;
`ifdef PIPE_IO_HANDSHAKE_EN
   assign bus.io_req    = io_req_c;
`else
   assign bus.io_req    = 1'b0 & io_req_c;
`endif

   assign state         = state_q;
   assign stall_cycles  = stall_cycles_q;
   assign bubbles       = bubbles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl (CNT_W=4). It runs directed
// scenarios and then randomized traffic. Every cycle it compares the DUT
// against a behavioural model of the hazard rules.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   localparam int unsigned W    = 4;
   localparam int          CMAX = (1 << W) - 1;

`ifdef PIPE_IO_HANDSHAKE_EN
   localparam bit IO_EN = 1'b1;
`else
   localparam bit IO_EN = 1'b0;
`endif

   // Model waiting modes, in the spec's own numbering.
   localparam int M_RUN = 0, M_LDUSE = 1, M_MEMW = 2, M_IOW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    state;
   logic [W-1:0]  sc;
   logic [W-1:0]  bb;

   int n_cmp = 0;
   int n_err = 0;

   int m_mode = M_RUN;
   int m_sc   = 0;
   int m_bb   = 0;

   pipe_hazard_ctrl_if bus ();

   pipe_hazard_ctrl #(.CNT_W(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .state        (state),
      .stall_cycles (sc),
      .bubbles      (bb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      rst              = 1'b1;
      bus.id_read_reg1 = 1'b0;
      bus.id_read_reg2 = 1'b0;
      bus.id_readf1    = 1'b0;
      bus.id_readf2    = 1'b0;
      bus.id_reg1_addr = 5'd0;
      bus.id_reg2_addr = 5'd0;
      bus.ex_mem_read  = 1'b0;
      bus.ex_reg_write = 1'b0;
      bus.ex_writef    = 1'b0;
      bus.ex_write_reg = 5'd0;
      bus.ex_data_in   = 1'b0;
      bus.ex_data_out  = 1'b0;
      bus.branch_wrong = 1'b0;
      bus.mem_busy     = 1'b0;
      bus.io_ack       = 1'b0;
   endtask

   // Does any enabled decode source need the value still being loaded?
   function automatic bit model_ldhit();
      bit          en [2];
      bit          fl [2];
      logic [4:0]  ad [2];
      bit          hit = 1'b0;
      en[0] = bus.id_read_reg1 | bus.id_readf1;
      en[1] = bus.id_read_reg2 | bus.id_readf2;
      fl[0] = bus.id_readf1;
      fl[1] = bus.id_readf2;
      ad[0] = bus.id_reg1_addr;
      ad[1] = bus.id_reg2_addr;
      for (int s = 0; s < 2; s++) begin
         if (en[s] && (fl[s] == bus.ex_writef) && (ad[s] == bus.ex_write_reg)
             && (fl[s] || ad[s] != 5'd0))
            hit = 1'b1;
      end
      return bus.ex_mem_read && bus.ex_reg_write && hit;
   endfunction

   // Expected controls for this cycle and the mode the pipe moves to next.
   function automatic void model_eval(output bit e_stall, output bit e_bub,
                                      output bit e_req, output int nxt);
      e_stall = 1'b0;
      e_bub   = 1'b0;
      e_req   = 1'b0;
      nxt     = M_RUN;
      if (!rst) return;
      if (m_mode == M_RUN) begin
         if (bus.branch_wrong) begin
            nxt = M_RUN;
         end else if (bus.mem_busy) begin
            nxt = M_MEMW; e_stall = 1'b1;
         end else if (IO_EN && (bus.ex_data_in || bus.ex_data_out)) begin
            nxt = M_IOW; e_stall = 1'b1; e_req = 1'b1;
         end else if (model_ldhit()) begin
            nxt = M_LDUSE; e_stall = 1'b1; e_bub = 1'b1;
         end
      end else if (m_mode == M_MEMW) begin
         e_stall = bus.mem_busy;
         nxt     = bus.mem_busy ? M_MEMW : M_RUN;
      end else if (m_mode == M_IOW) begin
         e_stall = !bus.io_ack;
         e_req   = !bus.io_ack;
         nxt     = bus.io_ack ? M_RUN : M_IOW;
      end
   endfunction

   // One clock: inputs have been set just after a falling edge. Check the
   // outputs, let the rising edge pass, and advance the model.
   task automatic cycle();
      bit e_stall, e_bub, e_req;
      int nxt;
      #1;
      model_eval(e_stall, e_bub, e_req, nxt);
      chk("stall",        32'(bus.stall),     32'(e_stall));
      chk("bubble_ex",    32'(bus.bubble_ex), 32'(e_bub));
      chk("io_req",       32'(bus.io_req),    32'(e_req));
      chk("state",        32'(state),         32'(m_mode));
      chk("stall_cycles", 32'(sc),            32'(m_sc));
      chk("bubbles",      32'(bb),            32'(m_bb));
      if (!rst) begin
         m_mode = M_RUN; m_sc = 0; m_bb = 0;
      end else begin
         m_mode = nxt;
         if (e_stall && m_sc < CMAX) m_sc++;
         if (e_bub   && m_bb < CMAX) m_bb++;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b0;
      cycle();
      rst = 1'b1;
   endtask

   task automatic set_load(input bit f, input logic [4:0] rd);
      bus.ex_mem_read  = 1'b1;
      bus.ex_reg_write = 1'b1;
      bus.ex_writef    = f;
      bus.ex_write_reg = rd;
   endtask

   task automatic randomize_inputs();
      rst              = ($urandom_range(0, 49) != 0);
      bus.id_read_reg1 = 1'($urandom_range(0, 1));
      bus.id_read_reg2 = 1'($urandom_range(0, 1));
      bus.id_readf1    = ($urandom_range(0, 3) == 0);
      bus.id_readf2    = ($urandom_range(0, 3) == 0);
      bus.id_reg1_addr = 5'($urandom_range(0, 3));
      bus.id_reg2_addr = 5'($urandom_range(0, 3));
      bus.ex_mem_read  = ($urandom_range(0, 2) != 0);
      bus.ex_reg_write = ($urandom_range(0, 3) != 0);
      bus.ex_writef    = ($urandom_range(0, 3) == 0);
      bus.ex_write_reg = 5'($urandom_range(0, 3));
      bus.ex_data_in   = ($urandom_range(0, 9) == 0);
      bus.ex_data_out  = ($urandom_range(0, 9) == 0);
      bus.branch_wrong = ($urandom_range(0, 9) == 0);
      bus.mem_busy     = ($urandom_range(0, 4) == 0);
      bus.io_ack       = ($urandom_range(0, 4) == 0);
   endtask

   initial begin
      clear_inputs();
      @(negedge clk);

      // Reset state.
      do_reset();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_cnt",   32'(sc),    32'd0);

      // Basic load-use: one bubble, then RUN.
      set_load(1'b0, 5'd5);
      bus.id_read_reg1 = 1'b1;
      bus.id_reg1_addr = 5'd5;
      cycle();
      clear_inputs();
      cycle();
      cycle();
      chk("lu_bubbles", 32'(bb),    32'd1);
      chk("lu_state",   32'(state), 32'd0);

      // Integer x0 never matches; a float load never matches an int source.
      do_reset();
      set_load(1'b0, 5'd0);
      bus.id_read_reg1 = 1'b1;
      bus.id_reg1_addr = 5'd0;
      cycle();
      clear_inputs();
      set_load(1'b1, 5'd5);
      bus.id_read_reg2 = 1'b1;
      bus.id_reg2_addr = 5'd5;
      cycle();
      chk("rf_type_nostall", 32'(sc), 32'd0);
      // Float f0 is a real register.
      clear_inputs();
      set_load(1'b1, 5'd0);
      bus.id_readf2    = 1'b1;
      bus.id_reg2_addr = 5'd0;
      cycle();
      clear_inputs();
      cycle();
      chk("f0_bubbles", 32'(bb), 32'd1);

      // Memory wait: three busy cycles, three stall cycles.
      do_reset();
      bus.mem_busy = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
      bus.mem_busy = 1'b0;
      cycle();
      chk("memw_cnt",   32'(sc),    32'd3);
      chk("memw_state", 32'(state), 32'd0);

`ifdef PIPE_IO_HANDSHAKE_EN
      // UART handshake: io_ack four cycles after io_req rises.
      do_reset();
      bus.ex_data_out = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
      bus.io_ack = 1'b1;
      cycle();
      clear_inputs();
      cycle();
      chk("io_stall_cnt", 32'(sc),    32'd4);
      chk("io_state",     32'(state), 32'd0);

      // Reset in the middle of IOW aborts the transfer.
      bus.ex_data_out = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      cycle();
      clear_inputs();
      chk("iow_rst_state", 32'(state), 32'd0);
      chk("iow_rst_cnt",   32'(sc),    32'd0);
      cycle();
`else
      // Without the handshake an out instruction costs nothing.
      do_reset();
      bus.ex_data_out = 1'b1;
      cycle();
      cycle();
      clear_inputs();
      chk("noio_cnt",   32'(sc),    32'd0);
      chk("noio_state", 32'(state), 32'd0);
`endif

      // Mispredict beats load-use.
      do_reset();
      set_load(1'b0, 5'd7);
      bus.id_read_reg1 = 1'b1;
      bus.id_reg1_addr = 5'd7;
      bus.branch_wrong = 1'b1;
      cycle();
      clear_inputs();
      cycle();
      chk("bw_bubbles", 32'(bb), 32'd0);

      // mem_busy beats load-use in the same cycle.
      set_load(1'b0, 5'd7);
      bus.id_read_reg1 = 1'b1;
      bus.id_reg1_addr = 5'd7;
      bus.mem_busy     = 1'b1;
      cycle();
      chk("mb_state",   32'(state), 32'd2);
      chk("mb_bubbles", 32'(bb),    32'd0);
      clear_inputs();
      cycle();
      cycle();

      // Counter saturation at 15 for CNT_W=4.
      do_reset();
      bus.mem_busy = 1'b1;
      for (int i = 0; i < 20; i++) cycle();
      chk("sat_cnt", 32'(sc), 32'd15);
      bus.mem_busy = 1'b0;
      cycle();

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         randomize_inputs();
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
